// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64 architectural register file.
package regfile_pkg;

  localparam int DATA_W    = 64;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  // Index 31 is XZR: reads as zero, writes are dropped.
  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;

endpackage

// File: rtl/regfile_32x64_decoder5_32.sv
// Binary-to-one-hot write decoder: one output per register, all low when
// the enable is low so unknown index bits cannot reach the register enables.
module decoder5_32
  import regfile_pkg::*;
#(
  parameter int IDX_W = REG_IDX_W,
  parameter int N_OUT = 1 << REG_IDX_W
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N_OUT-1:0] o_onehot
);

  // Compare against every output position; widths below 2**IDX_W simply
  // never assert for the missing upper indices.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      o_onehot[i] = i_en && (i_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/regfile_32x64.sv
// Architectural register file: X0..X30 in flops, X31 (XZR) hard-wired to
// zero, two combinational read ports and one write port on rising clk.
// Optional build macro REGFILE_BYPASS_EN forwards WriteData to a read port
// addressing the register being written in the same cycle.
module regfile_32x64
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [AW-1:0]     WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [AW-1:0]     ReadRegister1,
  input  logic [AW-1:0]     ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int NUM_STORED = NUM_REGS - 1;

  logic [DATA_W-1:0]     r_regs [NUM_STORED];
  logic [DATA_W-1:0]     w_bank [NUM_REGS];
  logic [NUM_STORED-1:0] w_wr_en;

  // Only the stored registers get an enable, so a write to XZR decodes to
  // nothing and is dropped without a separate compare.
  decoder5_32 #(
    .IDX_W (AW),
    .N_OUT (NUM_STORED)
  ) u_wr_dec (
    .i_idx    (WriteRegister),
    .i_en     (RegWrite),
    .o_onehot (w_wr_en)
  );

  // Register bank: async clear, per-register load enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STORED; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STORED; i++) begin
        if (w_wr_en[i]) r_regs[i] <= WriteData;
      end
    end
  end

  // Read view of all indices with the zero register appended at the top.
  always_comb begin
    for (int i = 0; i < NUM_STORED; i++) begin
      w_bank[i] = r_regs[i];
    end
    w_bank[NUM_REGS-1] = '0;
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [AW-1:0] XZR = AW'(NUM_REGS - 1);

  logic w_fwd1;
  logic w_fwd2;

  // Forward only for a real write to a stored register outside reset.
  always_comb begin
    w_fwd1 = RegWrite && !reset && (WriteRegister != XZR) &&
             (WriteRegister == ReadRegister1);
    w_fwd2 = RegWrite && !reset && (WriteRegister != XZR) &&
             (WriteRegister == ReadRegister2);
  end

  // Read ports with same-cycle write forwarding.
  always_comb begin
    ReadData1 = w_fwd1 ? WriteData : w_bank[ReadRegister1];
    ReadData2 = w_fwd2 ? WriteData : w_bank[ReadRegister2];
  end
`else
  // Read ports reflect stored state only.
  always_comb begin
    ReadData1 = w_bank[ReadRegister1];
    ReadData2 = w_bank[ReadRegister2];
  end
`endif

endmodule
